// File: rtl/four_sub_serial_if.sv
// four_sub_serial_if: start/busy/done handshake and operand/result bundle for the serial subtractor.
interface four_sub_serial_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             overflow;
    logic             borrow;
    modport master (output start, a, b, input busy, done, diff, overflow, borrow);
    modport slave  (input start, a, b, output busy, done, diff, overflow, borrow);
endinterface

// File: rtl/four_sub_serial.sv
// four_sub_serial: bit-serial two's-complement subtractor, diff = a - b, one full-adder slice per clock.
module four_sub_serial #(parameter int WIDTH = 4) (
    input logic clk,
    input logic rst_n,
    four_sub_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sr, nb_sr, res_sr, diff_r, res_next;
    logic [CW-1:0] count;
    logic carry, a_msb, b_msb, busy_r, done_r, ovf_r, brw_r, s, c_next;
    assign s = a_sr[0] ^ nb_sr[0] ^ carry;
    assign c_next = (a_sr[0] & nb_sr[0]) | (a_sr[0] & carry) | (nb_sr[0] & carry);
    assign res_next = {s, res_sr[WIDTH-1:1]};
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.overflow = ovf_r;
    assign bus.borrow = brw_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            nb_sr  <= '0;
            res_sr <= '0;
            count  <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= '0;
            ovf_r  <= 1'b0;
            brw_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sr   <= bus.a;
                    nb_sr  <= ~bus.b;
                    carry  <= 1'b1;
                    count  <= '0;
                    a_msb  <= bus.a[WIDTH-1];
                    b_msb  <= bus.b[WIDTH-1];
                    busy_r <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    nb_sr  <= nb_sr >> 1;
                    res_sr <= res_next;
                    carry  <= c_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        // res_next already holds the MSB computed on this edge
                        diff_r <= res_next;
                        brw_r  <= ~c_next;
                        ovf_r  <= (a_msb != b_msb) & (s != a_msb);
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_four_sub_serial.sv
// tb_four_sub_serial: directed and random subtractions checked against an integer-arithmetic model.
module tb_four_sub_serial;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    four_sub_serial_if #(.WIDTH(W)) bus();
    four_sub_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {overflow, borrow, diff} from signed/unsigned integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, d;
        sa = int'($signed(a));
        sb = int'($signed(b));
        d = sa - sb;
        return {d > (2**(W-1) - 1) || d < -(2**(W-1)), int'(a) < int'(b), W'(int'(a) - int'(b))};
    endfunction

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke, input string tag);
        logic [W+1:0] exp;
        int busy_n, done_n, done_at;
        exp = model(a, b);
        busy_n = 0; done_n = 0; done_at = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 2) begin bus.start = 1'b1; bus.a = ~a; bus.b = a; end
            if (poke && k == 3) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin done_n++; done_at = k; end
            if (k == 5) begin
                check({tag, ".diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
                check({tag, ".ovf"}, 32'(bus.overflow), 32'(exp[W+1]));
                check({tag, ".borrow"}, 32'(bus.borrow), 32'(exp[W]));
            end
        end
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd5);
        check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        check({tag, ".done_cycle"}, 32'(done_at), 32'd5);
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W+1:0] exp;
        int last, pulses, bad;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #12;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.diff", 32'(bus.diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(4'b0011, 4'b0101, 1'b0, "basic");
        op(4'b0111, 4'b1111, 1'b0, "pos_ovf");
        op(4'b1000, 4'b0001, 1'b0, "neg_ovf");
        op(4'b0000, 4'b1000, 1'b0, "min_sub");
        op(4'b0101, 4'b0101, 1'b0, "zero");
        op(4'b0110, 4'b1011, 1'b1, "ignored_start");
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            op(ra, rb, ($urandom % 2) == 1, $sformatf("rand%0d", i));
        end
        // abort mid-run after a nonzero result is on display
        op(4'b0111, 4'b1111, 1'b0, "pre_reset");
        @(negedge clk);
        bus.a = 4'b0001; bus.b = 4'b0110; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.diff", 32'(bus.diff), 32'd0);
        check("abort.ovf", 32'(bus.overflow), 32'd0);
        check("abort.borrow", 32'(bus.borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) bad++;
        end
        check("abort.quiet", 32'(bad), 32'd0);
        // start held high: one completion every WIDTH+2 cycles
        ra = 4'b1010; rb = 4'b0011;
        exp = model(ra, rb);
        bus.a = ra; bus.b = rb; bus.start = 1'b1;
        last = -1; pulses = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last >= 0 && k - last != 6) bad++;
                if (bus.diff !== exp[W-1:0] || bus.overflow !== exp[W+1] || bus.borrow !== exp[W]) bad++;
                last = k;
                pulses++;
            end
        end
        bus.start = 1'b0;
        check("held.errors", 32'(bad), 32'd0);
        check("held.pulses", 32'(pulses >= 6), 32'd1);
        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/four_sub_serial.md
# four_sub_serial

Bit-serial two's-complement subtractor that computes Diff = A − B one bit per clock using a single full-adder slice, with a start/busy/done handshake. It is the inverse-direction companion to the combinational 4-bit ripple adder in the arithmetic lab datapath: same operand format, same overflow semantics, but subtraction with sequential control. It sits between the switch/operand registers and the seven-segment/LED result display.

## Interface

**Parameters**
- WIDTH, default 4: operand and result width in bits, two's complement; must be ≥ 2.

**Ports**
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a subtraction; sampled only in IDLE.
- A, input, WIDTH: minuend, two's complement; sampled on the accepting edge only.
- B, input, WIDTH: subtrahend, two's complement; sampled on the accepting edge only.
- busy, output, 1: high while the state is RUN or DONE.
- done, output, 1: one-cycle pulse, high exactly while the state is DONE.
- Diff, output, WIDTH: A − B mod 2^WIDTH; holds its value until the next completion.
- OverFlow, output, 1: signed overflow of the last completed operation; held with Diff.
- Borrow, output, 1: unsigned borrow (A < B unsigned) of the last completed operation; held with Diff.

## Operation

- **Reset.** While rst_n is low: state = IDLE, busy = 0, done = 0, Diff = 0, OverFlow = 0, Borrow = 0. Internal shift registers, bit counter and carry are also cleared.
- **Reset mid-operation.** Asserting rst_n during RUN or DONE aborts the operation. No partial result is ever presented.
- **FSM states.** IDLE, RUN, DONE.
- **IDLE → RUN** when start = 1 at a rising edge. On that edge:
  - a_sr ← A and nb_sr ← ~B;
  - carry ← 1, so that A + ~B + 1 = A − B;
  - count ← 0;
  - the MSBs of A and B are latched for the overflow calculation.
- **RUN, each edge (bit slice):**
  - s = a_sr[0] ^ nb_sr[0] ^ carry;
  - carry ← majority(a_sr[0], nb_sr[0], carry);
  - a_sr and nb_sr shift right by one;
  - s shifts into the MSB of res_sr, which shifts right;
  - count increments.
- **RUN → DONE** on the edge that processes bit WIDTH−1 (count = WIDTH−1). On that same edge:
  - Diff ← the final result, including the bit computed on that edge;
  - Borrow ← ~(final carry out);
  - OverFlow ← (A_msb ≠ B_msb) & (Diff_msb ≠ A_msb).
- **DONE → IDLE** unconditionally on the next edge.
- **Ignored start.** start is ignored in RUN and DONE. It is not queued. If start is still high after the return to IDLE, a new operation is accepted on the following edge.
- **Operand hold.** A and B may change freely after the accepting edge without affecting the result.
- **Arithmetic rules.**
  - Result wraps modulo 2^WIDTH.
  - OverFlow equals the rule used by the combinational adder applied to A + (−B), except that B = −2^(WIDTH−1) is handled correctly by the ~B+1 formulation.

## Timing

- **Accepting edge** = E0 (IDLE with start = 1). busy rises after E0.
- **Bit processing.** Bits 0..WIDTH−1 are processed on edges E1..E_WIDTH.
- **Completion.** done, and the updated Diff/OverFlow/Borrow, are valid after E_WIDTH, for one cycle of done.
- **Return to idle.** After E_WIDTH+1: state = IDLE, busy = 0, done = 0.
- **Latency.** WIDTH+1 edges from accept to done. For WIDTH = 4, done is high in the 5th cycle after start is sampled.
- **Throughput.** One operation per WIDTH+2 cycles with start held high.
- **Output registration.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset values.** Assert rst_n = 0 mid-RUN → busy, done, Diff, OverFlow and Borrow all read 0 immediately (asynchronous). After release, state is IDLE and no done pulse appears.
- **Basic subtraction (WIDTH = 4).** A = 0011, B = 0101, start for one cycle:
  - busy is high for 5 cycles;
  - done pulses once, in the 5th cycle after the start edge;
  - Diff = 1110 (−2), OverFlow = 0, Borrow = 1.
- **Positive overflow.** A = 0111, B = 1111 → Diff = 1000, OverFlow = 1, Borrow = 1.
- **Negative overflow.** A = 1000, B = 0001 → Diff = 0111, OverFlow = 1, Borrow = 0.
- **Most-negative subtrahend and zero result.**
  - A = 0000, B = 1000 → Diff = 1000, OverFlow = 1.
  - Then A = 0101, B = 0101 → Diff = 0000, OverFlow = 0, Borrow = 0.
- **Handshake rules.**
  - Pulse start again during RUN with different operands → ignored, result reflects only the first operands.
  - Changing A/B after acceptance does not alter Diff.
  - Holding start high continuously → done pulses every 6 cycles.
